// File: rtl/vga_rect_fill_if.sv
// Command and frame-buffer write bundle for vga_rect_fill.
// master drives rectangle commands; slave is the filler that answers with pixel writes.
interface vga_rect_fill_if #(
   parameter int COORD_W = 11
);
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic [COORD_W-1:0] cmd_x_i;
   logic [COORD_W-1:0] cmd_y_i;
   logic [COORD_W-1:0] cmd_w_i;
   logic [COORD_W-1:0] cmd_h_i;
   logic [1:0]         cmd_color_i;
   logic               abort_i;
   logic [COORD_W-1:0] addr_x_o;
   logic [COORD_W-1:0] addr_y_o;
   logic [1:0]         color_o;
   logic               we_o;
   logic               busy_o;
   logic               done_o;

   modport master (
      output cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, abort_i,
      input  cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
   );

   modport slave (
      input  cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, abort_i,
      output cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
   );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle filler: one frame-buffer write per cycle in raster order per accepted command.
// Define VGA_RECT_CLIP_EN to clamp rectangles to the MAX_H x MAX_V visible area.
module vga_rect_fill #(
   parameter int COORD_W = 11,
   parameter int MAX_H   = 800,
   parameter int MAX_V   = 600
) (
   input  logic           clk_i,
   input  logic           arstn_i,
   vga_rect_fill_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

   if (MAX_H >= (1 << COORD_W) || MAX_V >= (1 << COORD_W)) begin : g_bad_limits
      $error("vga_rect_fill: MAX_H and MAX_V must be below 2**COORD_W");
   end

   logic [1:0]         state;
   logic [COORD_W-1:0] x0_r, y0_r, w_r, h_r;
   logic [COORD_W-1:0] x_cnt, y_cnt;
   logic [COORD_W-1:0] addr_x_p1, addr_y_p1;
   logic [1:0]         color_p1;
   logic               vld_p1, ready_p1, busy_p1, done_p1;

   logic [COORD_W-1:0] w_eff, h_eff;
   logic [COORD_W-1:0] x_cnt_nxt, y_cnt_nxt;
   logic               hs, cmd_empty, last_x, last_px;

`ifdef VGA_RECT_CLIP_EN
   // Saturate a run length to the room left before the visible edge.
   function automatic logic [COORD_W-1:0] clip_len(
      input logic [COORD_W-1:0] org,
      input logic [COORD_W-1:0] len,
      input int                 lim
   );
      logic [COORD_W-1:0] room;
      room = COORD_W'(lim) - org;
      return (len > room) ? room : len;
   endfunction

   assign w_eff = (bus.cmd_x_i >= COORD_W'(MAX_H)) ? '0 : clip_len(bus.cmd_x_i, bus.cmd_w_i, MAX_H);
   assign h_eff = (bus.cmd_y_i >= COORD_W'(MAX_V)) ? '0 : clip_len(bus.cmd_y_i, bus.cmd_h_i, MAX_V);
`else
   assign w_eff = bus.cmd_w_i;
   assign h_eff = bus.cmd_h_i;
`endif

   assign hs        = bus.cmd_valid_i && ready_p1;
   assign cmd_empty = (w_eff == '0) || (h_eff == '0);
   assign last_x    = (x_cnt == w_r - C_ONE);
   assign last_px   = last_x && (y_cnt == h_r - C_ONE);
   assign x_cnt_nxt = last_x ? '0 : x_cnt + C_ONE;
   assign y_cnt_nxt = last_x ? y_cnt + C_ONE : y_cnt;

   // p1: registered write port and status; addresses wrap modulo 2^COORD_W
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state     <= S_IDLE;
         x0_r      <= '0;
         y0_r      <= '0;
         w_r       <= '0;
         h_r       <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         addr_x_p1 <= '0;
         addr_y_p1 <= '0;
         color_p1  <= '0;
         vld_p1    <= 1'b0;
         ready_p1  <= 1'b1;
         busy_p1   <= 1'b0;
         done_p1   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hs) begin
                  x0_r     <= bus.cmd_x_i;
                  y0_r     <= bus.cmd_y_i;
                  w_r      <= w_eff;
                  h_r      <= h_eff;
                  color_p1 <= bus.cmd_color_i;
                  x_cnt    <= '0;
                  y_cnt    <= '0;
                  ready_p1 <= 1'b0;
                  if (cmd_empty) begin
                     state   <= S_DONE;
                     done_p1 <= 1'b1;
                  end else begin
                     state     <= S_FILL;
                     busy_p1   <= 1'b1;
                     vld_p1    <= 1'b1;
                     addr_x_p1 <= bus.cmd_x_i;
                     addr_y_p1 <= bus.cmd_y_i;
                  end
               end
            end
            S_FILL: begin
               if (bus.abort_i || last_px) begin
                  vld_p1    <= 1'b0;
                  busy_p1   <= 1'b0;
                  addr_x_p1 <= '0;
                  addr_y_p1 <= '0;
                  if (bus.abort_i) begin
                     state    <= S_IDLE;
                     ready_p1 <= 1'b1;
                  end else begin
                     state   <= S_DONE;
                     done_p1 <= 1'b1;
                  end
               end else begin
                  x_cnt     <= x_cnt_nxt;
                  y_cnt     <= y_cnt_nxt;
                  addr_x_p1 <= x0_r + x_cnt_nxt;
                  addr_y_p1 <= y0_r + y_cnt_nxt;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               done_p1  <= 1'b0;
               ready_p1 <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               vld_p1    <= 1'b0;
               busy_p1   <= 1'b0;
               done_p1   <= 1'b0;
               ready_p1  <= 1'b1;
               addr_x_p1 <= '0;
               addr_y_p1 <= '0;
            end
         endcase
      end
   end

   assign bus.cmd_ready_o = ready_p1;
   assign bus.addr_x_o    = addr_x_p1;
   assign bus.addr_y_o    = addr_y_p1;
   assign bus.color_o     = color_p1;
   assign bus.we_o        = vld_p1;
   assign bus.busy_o      = busy_p1;
   assign bus.done_o      = done_p1;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: raster fills, empty commands, back-to-back, abort, reset, wrap/clip.
module tb_vga_rect_fill;
   logic clk;
   logic arstn;
   int   n_assert;
   int   n_fail;

   vga_rect_fill_if #(.COORD_W(11)) bus ();

   vga_rect_fill #(.COORD_W(11), .MAX_H(800), .MAX_V(600)) dut (
      .clk_i   (clk),
      .arstn_i (arstn),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int x, input int y, input int w, input int h, input int col);
      bus.cmd_x_i     = 11'(x);
      bus.cmd_y_i     = 11'(y);
      bus.cmd_w_i     = 11'(w);
      bus.cmd_h_i     = 11'(h);
      bus.cmd_color_i = 2'(col);
      bus.cmd_valid_i = 1'b1;
   endtask

   task automatic chk_px(input string tag, input int x, input int y, input int col);
      chk({tag, "_we"},    32'(bus.we_o),        32'd1);
      chk({tag, "_x"},     32'(bus.addr_x_o),    32'(x));
      chk({tag, "_y"},     32'(bus.addr_y_o),    32'(y));
      chk({tag, "_col"},   32'(bus.color_o),     32'(col));
      chk({tag, "_busy"},  32'(bus.busy_o),      32'd1);
      chk({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'd0);
   endtask

   task automatic expect_done(input string tag);
      chk({tag, "_done_we"},    32'(bus.we_o),        32'd0);
      chk({tag, "_done_pulse"}, 32'(bus.done_o),      32'd1);
      chk({tag, "_done_busy"},  32'(bus.busy_o),      32'd0);
      chk({tag, "_done_ready"}, 32'(bus.cmd_ready_o), 32'd0);
      chk({tag, "_done_ax"},    32'(bus.addr_x_o),    32'd0);
      tick();
      chk({tag, "_idle_done"},  32'(bus.done_o),      32'd0);
      chk({tag, "_idle_ready"}, 32'(bus.cmd_ready_o), 32'd1);
      chk({tag, "_idle_we"},    32'(bus.we_o),        32'd0);
   endtask

   task automatic expect_fill(input string tag, input int x0, input int y0,
                              input int w, input int h, input int col);
      for (int j = 0; j < h; j++) begin
         for (int i = 0; i < w; i++) begin
            chk_px(tag, (x0 + i) % 2048, (y0 + j) % 2048, col);
            tick();
         end
      end
      expect_done(tag);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      arstn    = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_x_i     = '0;
      bus.cmd_y_i     = '0;
      bus.cmd_w_i     = '0;
      bus.cmd_h_i     = '0;
      bus.cmd_color_i = '0;
      bus.abort_i     = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("rst_we",    32'(bus.we_o),        32'd0);
      chk("rst_busy",  32'(bus.busy_o),      32'd0);
      chk("rst_done",  32'(bus.done_o),      32'd0);
      chk("rst_ax",    32'(bus.addr_x_o),    32'd0);
      chk("rst_ay",    32'(bus.addr_y_o),    32'd0);
      chk("rst_col",   32'(bus.color_o),     32'd0);
      arstn = 1'b1;
      tick();
      chk("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);

      // basic 3x2 fill
      send(10, 20, 3, 2, 2);
      tick();
      bus.cmd_valid_i = 1'b0;
      expect_fill("t1", 10, 20, 3, 2, 2);

      // empty command: no writes, done next cycle
      send(3, 4, 0, 5, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("t2_busy", 32'(bus.busy_o), 32'd0);
      expect_done("t2");

      // back-to-back with valid held high
      send(100, 50, 2, 1, 3);
      tick();
      send(5, 6, 1, 2, 1);
      expect_fill("t3a", 100, 50, 2, 1, 3);
      tick();
      bus.cmd_valid_i = 1'b0;
      expect_fill("t3b", 5, 6, 1, 2, 1);

      // abort on the 4th write of a 4x4 fill
      send(200, 300, 4, 4, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_px("t4", 200 + i, 300, 1);
         if (i == 3) bus.abort_i = 1'b1;
         tick();
      end
      bus.abort_i = 1'b0;
      chk("t4_we",    32'(bus.we_o),        32'd0);
      chk("t4_done",  32'(bus.done_o),      32'd0);
      chk("t4_busy",  32'(bus.busy_o),      32'd0);
      chk("t4_ready", 32'(bus.cmd_ready_o), 32'd1);
      tick();
      chk("t4_done2", 32'(bus.done_o),      32'd0);
      chk("t4_we2",   32'(bus.we_o),        32'd0);

      // async reset mid-fill, then a fresh command (abort at handshake is ignored)
      send(1, 1, 4, 4, 2);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk_px("t5a", 1, 1, 2);
      tick();
      chk_px("t5b", 2, 1, 2);
      arstn = 1'b0;
      #1;
      chk("t5_rst_we",    32'(bus.we_o),        32'd0);
      chk("t5_rst_busy",  32'(bus.busy_o),      32'd0);
      chk("t5_rst_done",  32'(bus.done_o),      32'd0);
      chk("t5_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("t5_rst_ax",    32'(bus.addr_x_o),    32'd0);
      tick();
      arstn = 1'b1;
      tick();
      send(7, 8, 2, 2, 3);
      bus.abort_i = 1'b1;
      tick();
      bus.cmd_valid_i = 1'b0;
      bus.abort_i     = 1'b0;
      expect_fill("t5c", 7, 8, 2, 2, 3);

`ifdef VGA_RECT_CLIP_EN
      // clipped at the right edge, and an origin off-screen becomes empty
      send(798, 10, 5, 1, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
      expect_fill("t6_clip", 798, 10, 2, 1, 1);
      send(800, 0, 4, 4, 2);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("t6_off_we", 32'(bus.we_o), 32'd0);
      expect_done("t6_off");
`else
      // x wraps modulo 2^COORD_W
      send(2046, 10, 3, 1, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
      expect_fill("t6_wrap", 2046, 10, 3, 1, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
